// File: rtl/encoder_pkg.sv
// Shared types and helpers for the priority-encoder family.
// No logic of its own; pure declarations.
// No flow control; compile-time constants only.
package encoder_pkg;

  localparam bit DIR_LSB_FIRST = 1'b0;
  localparam bit DIR_MSB_FIRST = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Index width for an n-wide vector; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bitset_index_streamer_if.sv
// Request-vector input stream and index output stream for the streamer.
// No latency; signal bundle only.
// valid/ready on both sides; the producer holds in_vec until in_ready.
interface bitset_index_streamer_if #(
  parameter int N = 8
);
  localparam int IW = encoder_pkg::clog2_min1(N);

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_vec;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          out_none;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_last, out_none
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_last, out_none
  );

endinterface

// File: rtl/bitset_index_streamer_pri_enc.sv
// Parametrised priority encoder: index of first set bit in chosen direction.
// Purely combinational, zero latency.
// No flow control; idx is 0 when vec is all-zero.
module pri_enc
  import encoder_pkg::*;
#(
  parameter int N         = 8,
  parameter bit MSB_FIRST = DIR_LSB_FIRST,
  localparam int IW       = clog2_min1(N)
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          any,
  output logic          single
);

  // Scan so the winning bit is the last one assigned.
  always_comb begin
    idx = '0;
    if (MSB_FIRST == DIR_MSB_FIRST) begin
      for (int i = 0; i < N; i++) begin
        if (vec[i]) idx = IW'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (vec[i]) idx = IW'(i);
      end
    end
  end

  assign any    = |vec;
  // Clearing the lowest set bit leaves nothing iff at most one bit was set.
  assign single = ((vec & (vec - N'(1))) == '0);

endmodule

// File: rtl/bitset_index_streamer.sv
// Captures an N-bit vector, then streams the index of each set bit, one per beat.
// First beat visible the cycle after capture; one bubble cycle between vectors.
// Output fields hold while out_ready is low; in_ready is low while emitting.
module bitset_index_streamer
  import encoder_pkg::*;
#(
  parameter int N         = 8,
  parameter bit MSB_FIRST = DIR_LSB_FIRST
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bitset_index_streamer_if.slave bus,
  output logic                   busy
);

  localparam int IW = clog2_min1(N);

  state_t        state_q, state_d;
  logic [N-1:0]  pending_q, pending_d;
  logic          zero_q, zero_d;

  logic [IW-1:0] enc_idx;
  logic          enc_any;
  logic          enc_single;
  logic          beat_last;

  pri_enc #(
    .N        (N),
    .MSB_FIRST(MSB_FIRST)
  ) u_pri_enc (
    .vec   (pending_q),
    .idx   (enc_idx),
    .any   (enc_any),
    .single(enc_single)
  );

  // An empty pending vector always closes the beat sequence.
  assign beat_last = zero_q || !enc_any || enc_single;

  // State and held vector; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      zero_q    <= zero_d;
    end
  end

  // Next-state and beat outputs, all derived from registered state.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    zero_d        = zero_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_idx   = '0;
    bus.out_last  = 1'b0;
    bus.out_none  = 1'b0;
    busy          = 1'b0;

    unique case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          pending_d = bus.in_vec;
          zero_d    = (bus.in_vec == '0);
          state_d   = EMIT;
        end
      end
      EMIT: begin
        bus.out_valid = 1'b1;
        bus.out_idx   = zero_q ? '0 : enc_idx;
        bus.out_last  = beat_last;
        bus.out_none  = zero_q;
        busy          = 1'b1;
        if (bus.out_ready) begin
          if (beat_last) begin
            pending_d = '0;
            zero_d    = 1'b0;
            state_d   = IDLE;
          end else begin
            pending_d = pending_q & ~(N'(1) << enc_idx);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bitset_index_streamer.sv
module tb_bitset_index_streamer;
  import encoder_pkg::*;

  logic clk;
  logic rst_n;

  int n_cmp = 0;
  int n_bad = 0;

  // Per-DUT stimulus and observation, indexed by DUT number.
  // 0: N=8 LSB-first, 1: N=8 MSB-first, 2: N=16 LSB-first, 3: N=1.
  logic        in_valid_a  [4];
  logic [15:0] in_vec_a    [4];
  logic        out_ready_a [4];
  logic        in_ready_a  [4];
  logic        out_valid_a [4];
  logic [3:0]  out_idx_a   [4];
  logic        out_last_a  [4];
  logic        out_none_a  [4];
  logic        busy_a      [4];

  int width_c [4] = '{8, 8, 16, 1};
  bit msb_c   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  bitset_index_streamer_if #(.N(8))  if0 ();
  bitset_index_streamer_if #(.N(8))  if1 ();
  bitset_index_streamer_if #(.N(16)) if2 ();
  bitset_index_streamer_if #(.N(1))  if3 ();

  bitset_index_streamer #(.N(8),  .MSB_FIRST(DIR_LSB_FIRST)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0), .busy(busy_a[0]));
  bitset_index_streamer #(.N(8),  .MSB_FIRST(DIR_MSB_FIRST)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1), .busy(busy_a[1]));
  bitset_index_streamer #(.N(16), .MSB_FIRST(DIR_LSB_FIRST)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2), .busy(busy_a[2]));
  bitset_index_streamer #(.N(1),  .MSB_FIRST(DIR_LSB_FIRST)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3), .busy(busy_a[3]));

  assign if0.in_valid = in_valid_a[0];  assign if0.in_vec = in_vec_a[0][7:0];  assign if0.out_ready = out_ready_a[0];
  assign if1.in_valid = in_valid_a[1];  assign if1.in_vec = in_vec_a[1][7:0];  assign if1.out_ready = out_ready_a[1];
  assign if2.in_valid = in_valid_a[2];  assign if2.in_vec = in_vec_a[2];       assign if2.out_ready = out_ready_a[2];
  assign if3.in_valid = in_valid_a[3];  assign if3.in_vec = in_vec_a[3][0:0];  assign if3.out_ready = out_ready_a[3];

  assign in_ready_a[0] = if0.in_ready;  assign out_valid_a[0] = if0.out_valid;  assign out_idx_a[0] = {1'b0, if0.out_idx};
  assign in_ready_a[1] = if1.in_ready;  assign out_valid_a[1] = if1.out_valid;  assign out_idx_a[1] = {1'b0, if1.out_idx};
  assign in_ready_a[2] = if2.in_ready;  assign out_valid_a[2] = if2.out_valid;  assign out_idx_a[2] = if2.out_idx;
  assign in_ready_a[3] = if3.in_ready;  assign out_valid_a[3] = if3.out_valid;  assign out_idx_a[3] = {3'b000, if3.out_idx};
  assign out_last_a[0] = if0.out_last;  assign out_none_a[0] = if0.out_none;
  assign out_last_a[1] = if1.out_last;  assign out_none_a[1] = if1.out_none;
  assign out_last_a[2] = if2.out_last;  assign out_none_a[2] = if2.out_none;
  assign out_last_a[3] = if3.out_last;  assign out_none_a[3] = if3.out_none;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input int d, input string tag);
    check({tag, "_out_valid"}, 32'(out_valid_a[d]), 32'd0);
    check({tag, "_in_ready"},  32'(in_ready_a[d]),  32'd1);
    check({tag, "_busy"},      32'(busy_a[d]),      32'd0);
  endtask

  // Reference: expected beats are the set-bit positions in scan order,
  // or a single index-0 "none" beat for a zero vector. Output readiness is
  // randomised with stall_pct, and the first beat is additionally stalled
  // for first_stall cycles.
  task automatic run_vec(input int d, input logic [15:0] v, input int stall_pct, input int first_stall);
    int  exp_q[$];
    int  w;
    int  b;
    int  guard;
    bit  none;
    bit  rdy;
    w = width_c[d];
    for (int k = 0; k < w; k++) begin
      b = msb_c[d] ? (w - 1 - k) : k;
      if (v[b]) exp_q.push_back(b);
    end
    none = (exp_q.size() == 0);
    if (none) exp_q.push_back(0);

    @(negedge clk);
    check("pre_in_ready", 32'(in_ready_a[d]), 32'd1);
    in_valid_a[d]  = 1'b1;
    in_vec_a[d]    = v;
    out_ready_a[d] = 1'b0;
    @(negedge clk);
    in_valid_a[d] = 1'b0;
    in_vec_a[d]   = 16'($urandom);
    for (int j = 0; j < exp_q.size(); j++) begin
      guard = 0;
      do begin
        check("out_valid", 32'(out_valid_a[d]), 32'd1);
        check("out_idx",   32'(out_idx_a[d]),   32'(exp_q[j]));
        check("out_last",  32'(out_last_a[d]),  32'(j == exp_q.size() - 1));
        check("out_none",  32'(out_none_a[d]),  32'(none));
        check("emit_in_ready", 32'(in_ready_a[d]), 32'd0);
        check("emit_busy", 32'(busy_a[d]), 32'd1);
        rdy = ($urandom_range(99) >= stall_pct);
        if (j == 0 && guard < first_stall) rdy = 1'b0;
        if (guard >= 20) rdy = 1'b1;
        out_ready_a[d] = rdy;
        in_vec_a[d]    = 16'($urandom);
        @(negedge clk);
        guard++;
      end while (!rdy);
      out_ready_a[d] = 1'b0;
    end
    check_idle(d, "after_last");
  endtask

  initial begin
    logic [15:0] v;
    logic [15:0] m;
    int          d;

    clk   = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid_a[i]  = 1'b0;
      in_vec_a[i]    = '0;
      out_ready_a[i] = 1'b0;
    end

    #12;
    for (int i = 0; i < 4; i++) begin
      check("rst_out_valid", 32'(out_valid_a[i]), 32'd0);
      check("rst_in_ready",  32'(in_ready_a[i]),  32'd1);
      check("rst_out_idx",   32'(out_idx_a[i]),   32'd0);
      check("rst_out_last",  32'(out_last_a[i]),  32'd0);
      check("rst_out_none",  32'(out_none_a[i]),  32'd0);
      check("rst_busy",      32'(busy_a[i]),      32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    run_vec(0, 16'h00A6, 0, 0);
    run_vec(1, 16'h00A6, 0, 0);
    run_vec(0, 16'h0000, 0, 0);
    run_vec(2, 16'h8001, 0, 3);

    // Mid-stream reset on an all-ones vector.
    @(negedge clk);
    in_valid_a[0]  = 1'b1;
    in_vec_a[0]    = 16'h00FF;
    out_ready_a[0] = 1'b1;
    @(negedge clk);
    in_valid_a[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("ff_out_idx", 32'(out_idx_a[0]), 32'(k));
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid_a[0]), 32'd0);
    check("arst_in_ready",  32'(in_ready_a[0]),  32'd1);
    check("arst_out_idx",   32'(out_idx_a[0]),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_out_valid", 32'(out_valid_a[0]), 32'd0);
    end
    out_ready_a[0] = 1'b0;
    run_vec(0, 16'h0010, 0, 0);

    // N=1, back-to-back with in_valid held high across the bubble.
    @(negedge clk);
    in_valid_a[3]  = 1'b1;
    in_vec_a[3]    = 16'h0001;
    out_ready_a[3] = 1'b1;
    @(negedge clk);
    check("n1_a_valid", 32'(out_valid_a[3]), 32'd1);
    check("n1_a_idx",   32'(out_idx_a[3]),   32'd0);
    check("n1_a_none",  32'(out_none_a[3]),  32'd0);
    check("n1_a_last",  32'(out_last_a[3]),  32'd1);
    in_vec_a[3] = 16'h0000;
    @(negedge clk);
    check("n1_bubble_valid", 32'(out_valid_a[3]), 32'd0);
    check("n1_bubble_ready", 32'(in_ready_a[3]),  32'd1);
    @(negedge clk);
    check("n1_b_valid", 32'(out_valid_a[3]), 32'd1);
    check("n1_b_idx",   32'(out_idx_a[3]),   32'd0);
    check("n1_b_none",  32'(out_none_a[3]),  32'd1);
    check("n1_b_last",  32'(out_last_a[3]),  32'd1);
    in_valid_a[3] = 1'b0;
    @(negedge clk);
    check_idle(3, "n1_end");
    out_ready_a[3] = 1'b0;

    // Randomised vectors with random backpressure across all widths/directions.
    for (int r = 0; r < 60; r++) begin
      d = int'($urandom_range(3));
      m = (width_c[d] == 16) ? 16'hFFFF : 16'((1 << width_c[d]) - 1);
      v = 16'($urandom) & m;
      if ($urandom_range(4) == 0) v = '0;
      run_vec(d, v, 30, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bitset_index_streamer.md
Name: bitset_index_streamer

Overview:
- Parametrised, sequential successor to the team's 8-to-3 encoders.
- Accepts an N-bit request vector on a valid/ready input handshake, then streams the index of every set bit, one per output beat, in fixed priority order.
- Sits between wide request/status vectors (interrupt pending, lane-active masks) and consumers that service one index at a time.
- Zero vectors are reported explicitly, never as X.

Parameters:
- N, 8, request vector width; legal range 1..1024.
- MSB_FIRST, 0, 0 = lowest set index emitted first; 1 = highest set index emitted first.
- IW, derived = max(1, clog2(N)), index width; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_vec is valid.
- in_ready  output  1  block can accept a vector.
- in_vec  input  N  request vector.
- out_valid  output  1  out_idx/out_last/out_none are valid.
- out_ready  input  1  consumer accepts the current beat.
- out_idx  output  IW  index of the current set bit.
- out_last  output  1  current beat is the final beat for this vector.
- out_none  output  1  captured vector was all-zero; single beat.
- busy  output  1  a vector is held (EMIT state).

Behaviour:
- Single clock domain clk. Reset: asynchronous, active-low, on rst_n.
- Reset values: state=IDLE, pending=0, out_valid=0, in_ready=1, out_idx=0, out_last=0, out_none=0, busy=0.
- Reset asserted mid-stream discards the held vector immediately. No beat is emitted after rst_n deasserts until a new vector is accepted.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - EMIT: in_ready=0, out_valid=1, busy=1.
- IDLE->EMIT on in_valid&&in_ready. pending<=in_vec; zero_flag<=(in_vec==0).
- Latency: a vector accepted at edge T gives out_valid=1 with its first index from edge T (visible in cycle T+1).
- Output beat fields, all derived from the pending/zero_flag registers (no input-to-output combinational path):
  - out_idx = priority index of pending (lowest set bit if MSB_FIRST=0, highest if 1); 0 when out_none.
  - out_last = 1 when pending has at most one bit set, or when zero_flag=1.
  - out_none = zero_flag.
- On out_valid&&out_ready in EMIT:
  - not out_last: clear the bit at out_idx in pending; stay in EMIT.
  - out_last: pending<=0, zero_flag<=0, go to IDLE.
- Throughput: one beat per cycle while out_ready=1. A vector with K set bits (K>=1) takes exactly K output handshakes; a zero vector takes exactly 1.
- Backpressure: while out_valid=1 and out_ready=0, out_idx/out_last/out_none hold stable.
- One bubble cycle between vectors: in_ready returns to 1 in the cycle after the last handshake. No overlap of capture and emission.
- in_vec is ignored whenever in_ready=0. in_valid may stay high across the bubble without loss.
- N=1: IW=1; out_idx is always 0; each vector gives one beat with out_none = !in_vec[0].
- No X is ever driven on any output, including the all-zero vector case.

Decomposition:
- Shared package encoder_pkg holds:
  - function clog2_min1(n), returns max(1, clog2(n));
  - state enum type {IDLE, EMIT};
  - constants DIR_LSB_FIRST=0 and DIR_MSB_FIRST=1.
- One sub-module: pri_enc.
  - Purely combinational, parametrised by N and MSB_FIRST.
  - Inputs: vec. Outputs: idx (IW wide), any, single (at most one bit set).
  - Instanced once on pending. Reusable as the parametrised replacement for the existing 8-to-3 encoders.

Test Plan:
- N=8, MSB_FIRST=0, in_vec=8'b1010_0110, out_ready=1 -> beats idx 1,2,5,7 on consecutive cycles. out_last=1 only on idx 7. in_ready=1 again the cycle after.
- N=8, MSB_FIRST=1, same vector -> idx 7,5,2,1; out_last on idx 1.
- N=8, in_vec=0 -> exactly one beat with out_none=1, out_idx=0, out_last=1. No X on any output.
- N=16, in_vec=16'h8001, out_ready low for 3 cycles after out_valid -> idx 0 held stable for all 3 cycles. Then idx 0 and idx 15 (last) each on one accepted cycle.
- N=8, in_vec=8'hFF, rst_n pulsed low after 3 beats -> out_valid=0 and in_ready=1 asynchronously. After release, no beats until a new vector; new in_vec=8'h10 gives a single beat idx 4 with out_last=1.
- N=1, in_vec=1 then in_vec=0 back-to-back with in_valid held high -> beat idx 0/out_none=0, bubble cycle, then beat out_none=1; both beats have out_last=1.
